// File: rtl/md_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_sequencer: control FSM for an iterative multiply/divide datapath.      |
// | Optional: MD_EARLY_DIV0_EN finishes a divide by zero without iterating.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module md_sequencer #(
    parameter int STEPS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ctrl_MULT,
    input  logic       ctrl_DIV,
    input  logic       operandB_zero,
    input  logic [4:0] i_rd,
    input  logic       flush,
    output logic       dp_load,
    output logic       dp_step,
    output logic       dp_div,
    output logic       dp_sign_fix,
    output logic [5:0] step_count,
    output logic       running,
    output logic       data_resultRDY,
    output logic       data_exception,
    output logic [4:0] o_rd
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        STEP = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

    state_t state;
    logic   bz_latched;
    logic   start;
    logic   div_req;
    logic   early_div0;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign div_req = ctrl_DIV & ~ctrl_MULT;

`ifdef MD_EARLY_DIV0_EN
    assign early_div0 = div_req & operandB_zero;
`else
    assign early_div0 = 1'b0;
`endif

    // Outputs are registered: each is set on the edge that enters its state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            dp_load        <= 1'b0;
            dp_step        <= 1'b0;
            dp_div         <= 1'b0;
            dp_sign_fix    <= 1'b0;
            step_count     <= 6'd0;
            running        <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            o_rd           <= 5'd0;
            bz_latched     <= 1'b0;
        end else begin
            dp_load        <= 1'b0;
            dp_step        <= 1'b0;
            dp_sign_fix    <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        running <= 1'b0;
                        state   <= IDLE;
                        if (start) begin
                            dp_div     <= div_req;
                            o_rd       <= i_rd;
                            bz_latched <= operandB_zero;
                            if (early_div0) begin
                                state          <= DONE;
                                data_resultRDY <= 1'b1;
                                data_exception <= 1'b1;
                            end else begin
                                state   <= LOAD;
                                dp_load <= 1'b1;
                                running <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        state      <= STEP;
                        dp_step    <= 1'b1;
                        step_count <= 6'd0;
                    end
                    STEP: begin
                        if (step_count == LAST_STEP) begin
                            state       <= FIX;
                            dp_sign_fix <= 1'b1;
                        end else begin
                            dp_step    <= 1'b1;
                            step_count <= step_count + 6'd1;
                        end
                    end
                    FIX: begin
                        state          <= DONE;
                        running        <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_exception <= dp_div & bz_latched;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_md_sequencer: scoreboard bench for md_sequencer.                       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_md_sequencer;

    localparam int STEPS = 32;

    logic       clk;
    logic       rst;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       operandB_zero;
    logic [4:0] i_rd;
    logic       flush;
    logic       dp_load;
    logic       dp_step;
    logic       dp_div;
    logic       dp_sign_fix;
    logic [5:0] step_count;
    logic       running;
    logic       data_resultRDY;
    logic       data_exception;
    logic [4:0] o_rd;

    md_sequencer #(.STEPS(STEPS)) dut (
        .clock          (clk),
        .reset          (rst),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .operandB_zero  (operandB_zero),
        .i_rd           (i_rd),
        .flush          (flush),
        .dp_load        (dp_load),
        .dp_step        (dp_step),
        .dp_div         (dp_div),
        .dp_sign_fix    (dp_sign_fix),
        .step_count     (step_count),
        .running        (running),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .o_rd           (o_rd)
    );

    typedef struct {
        int         due;
        logic [4:0] rd;
        logic       exc;
        logic       div;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rdy_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    // Scoreboard consumer plus per-cycle invariants.
    always @(negedge clk) begin
        if (!rst) begin
            check("invariants",
                  {31'd0, ($countones({dp_load, dp_step, dp_sign_fix}) > 1) ||
                          (data_exception && !data_resultRDY) ||
                          (running && data_resultRDY)}, 32'd0);
            if (data_resultRDY) begin
                rdy_seen++;
                if (exp_q.size() == 0) begin
                    check("spurious_rdy", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdy_cycle", cyc, e.due);
                    check("rdy_rd", {27'd0, o_rd}, {27'd0, e.rd});
                    check("rdy_exc", {31'd0, data_exception}, {31'd0, e.exc});
                    check("rdy_div", {31'd0, dp_div}, {31'd0, e.div});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 after the accepting edge.
    task automatic do_start(input logic m, input logic d, input logic bz, input logic [4:0] rd);
        exp_t e;
        int   lat;
        lat = STEPS + 2;
`ifdef MD_EARLY_DIV0_EN
        if (d && !m && bz) lat = 0;
`endif
        e.due = cyc + 1 + lat;
        e.rd  = rd;
        e.exc = d & ~m & bz;
        e.div = d & ~m;
        exp_q.push_back(e);
        ctrl_MULT = m; ctrl_DIV = d; operandB_zero = bz; i_rd = rd;
        @(negedge clk);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; operandB_zero = 1'b0; i_rd = 5'd0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_step10(input string tag);
        for (int i = 0; i < 60 && !(dp_step && step_count == 6'd10); i++) @(negedge clk);
        check(tag, {26'd0, step_count}, 32'd10);
    endtask

    initial begin
        int r0;
        rst = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; operandB_zero = 1'b0;
        i_rd = 5'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {dp_load, dp_step, dp_div, dp_sign_fix, running,
                              data_resultRDY, data_exception}, 0);
        check("rst_step_count", {26'd0, step_count}, 0);
        check("rst_o_rd", {27'd0, o_rd}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Multiply, full cycle-by-cycle profile.
        do_start(1'b1, 1'b0, 1'b0, 5'd7);
        for (int n = 1; n <= 35; n++) begin
            check("mul_load", {31'd0, dp_load}, {31'd0, n == 1});
            check("mul_step", {31'd0, dp_step}, {31'd0, n >= 2 && n <= 33});
            check("mul_fix", {31'd0, dp_sign_fix}, {31'd0, n == 34});
            check("mul_running", {31'd0, running}, {31'd0, n >= 1 && n <= 34});
            if (n >= 2 && n <= 33) check("mul_step_count", {26'd0, step_count}, n - 2);
            if (n < 35) @(negedge clk);
        end
        @(negedge clk);
        check("mul_rd_hold", {27'd0, o_rd}, 7);
        check("mul_idle_running", {31'd0, running}, 0);

        // Divide by zero.
        do_start(1'b0, 1'b1, 1'b1, 5'd12);
`ifdef MD_EARLY_DIV0_EN
        check("div0_running", {31'd0, running}, 0);
        check("div0_load", {31'd0, dp_load}, 0);
`else
        check("div0_running", {31'd0, running}, 1);
        check("div0_load", {31'd0, dp_load}, 1);
`endif
        wait_drain("div0_drain");

        // Multiply and divide together: multiply wins.
        do_start(1'b1, 1'b1, 1'b0, 5'd9);
        check("tie_div_c1", {31'd0, dp_div}, 0);
        repeat (20) @(negedge clk);
        check("tie_div_c21", {31'd0, dp_div}, 0);
        wait_drain("tie_drain");

        // Start during STEP is ignored.
        r0 = rdy_seen;
        do_start(1'b0, 1'b1, 1'b0, 5'd7);
        repeat (10) @(negedge clk);
        ctrl_DIV = 1'b1; operandB_zero = 1'b1; i_rd = 5'd3;
        @(negedge clk);
        ctrl_DIV = 1'b0; operandB_zero = 1'b0; i_rd = 5'd0;
        check("ign_rd", {27'd0, o_rd}, 7);
        check("ign_div", {31'd0, dp_div}, 1);
        repeat (30) @(negedge clk);
        wait_drain("ign_drain");
        check("ign_one_rdy", rdy_seen - r0, 1);

        // New start in the DONE cycle.
        do_start(1'b1, 1'b0, 1'b0, 5'd4);
        for (int i = 0; i < 100 && !data_resultRDY; i++) @(negedge clk);
        check("b2b_done", {31'd0, data_resultRDY}, 1);
        do_start(1'b0, 1'b1, 1'b0, 5'd6);
        check("b2b_load", {31'd0, dp_load}, 1);
        check("b2b_running", {31'd0, running}, 1);
        check("b2b_rd", {27'd0, o_rd}, 6);
        wait_drain("b2b_drain");

        // Flush at step_count 10.
        do_start(1'b1, 1'b0, 1'b0, 5'd11);
        wait_step10("flush_reach");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        check("flush_running", {31'd0, running}, 0);
        check("flush_step", {31'd0, dp_step}, 0);
        r0 = rdy_seen;
        repeat (40) @(negedge clk);
        check("flush_no_rdy", rdy_seen - r0, 0);

        // Reset at step_count 10, then start on the first edge after release.
        do_start(1'b0, 1'b1, 1'b0, 5'd13);
        wait_step10("rst_reach");
        rst = 1'b1;
        #1;
        check("rst_mid_running", {31'd0, running}, 0);
        check("rst_mid_step_count", {26'd0, step_count}, 0);
        check("rst_mid_rd", {27'd0, o_rd}, 0);
        check("rst_mid_div", {31'd0, dp_div}, 0);
        exp_q.delete();
        r0 = rdy_seen;
        @(negedge clk);
        rst = 1'b0;
        do_start(1'b1, 1'b0, 1'b0, 5'd2);
        check("post_rst_load", {31'd0, dp_load}, 1);
        wait_drain("post_rst_drain");
        check("post_rst_one_rdy", rdy_seen - r0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
